// File: rtl/fork_join_ctrl.sv
// fork_join_ctrl: forks two countdown jobs (A, B) per accepted start and
// issues one parent-continue pulse per fork under join / join_any / join_none.
module fork_join_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] dur_a,
    input  logic [CNT_W-1:0] dur_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic             done_a,
    output logic             done_b,
    output logic             join_done,
    output logic [3:0]       fork_id
);

    typedef enum logic [1:0] {
        MODE_JOIN = 2'b00,
        MODE_ANY  = 2'b01,
        MODE_NONE = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        JOB_IDLE = 1'b0,
        JOB_RUN  = 1'b1
    } job_state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    job_state_e       st_a_r, st_b_r, st_a_nxt_s, st_b_nxt_s;
    logic [CNT_W-1:0] cnt_a_r, cnt_b_r, cnt_a_nxt_s, cnt_b_nxt_s;
    mode_e            mode_r, mode_eff_s;
    logic             seen_a_r, seen_b_r, seen_a_nxt_s, seen_b_nxt_s;
    logic             fired_r, fired_eff_s, fire_s;
    logic             fin_a_s, fin_b_s;
    logic             accept_s;

    // Ready only when both children are idle and reset is released.
    assign start_ready = !rst && !busy_a && !busy_b;
    assign accept_s    = start_valid && start_ready;

    // Job A next state: load on accept, count down while running.
    always_comb begin
        st_a_nxt_s  = st_a_r;
        cnt_a_nxt_s = cnt_a_r;
        fin_a_s     = 1'b0;
        if (accept_s) begin
            cnt_a_nxt_s = dur_a;
            if (dur_a != CNT_ZERO) begin
                st_a_nxt_s = JOB_RUN;
            end else begin
                st_a_nxt_s = JOB_IDLE;
                fin_a_s    = 1'b1;
            end
        end else if (st_a_r == JOB_RUN) begin
            cnt_a_nxt_s = cnt_a_r - CNT_ONE;
            if (cnt_a_r == CNT_ONE) begin
                st_a_nxt_s = JOB_IDLE;
                fin_a_s    = 1'b1;
            end else begin
                st_a_nxt_s = JOB_RUN;
            end
        end else begin
            st_a_nxt_s = JOB_IDLE;
        end
    end

    // Job B next state: identical to job A.
    always_comb begin
        st_b_nxt_s  = st_b_r;
        cnt_b_nxt_s = cnt_b_r;
        fin_b_s     = 1'b0;
        if (accept_s) begin
            cnt_b_nxt_s = dur_b;
            if (dur_b != CNT_ZERO) begin
                st_b_nxt_s = JOB_RUN;
            end else begin
                st_b_nxt_s = JOB_IDLE;
                fin_b_s    = 1'b1;
            end
        end else if (st_b_r == JOB_RUN) begin
            cnt_b_nxt_s = cnt_b_r - CNT_ONE;
            if (cnt_b_r == CNT_ONE) begin
                st_b_nxt_s = JOB_IDLE;
                fin_b_s    = 1'b1;
            end else begin
                st_b_nxt_s = JOB_RUN;
            end
        end else begin
            st_b_nxt_s = JOB_IDLE;
        end
    end

    // Join policy: the accept edge uses the incoming mode and starts a fresh
    // fork (completion history and the fired flag are cleared).
    always_comb begin
        mode_eff_s   = accept_s ? mode_e'(mode) : mode_r;
        fired_eff_s  = accept_s ? 1'b0 : fired_r;
        seen_a_nxt_s = accept_s ? fin_a_s : (seen_a_r | fin_a_s);
        seen_b_nxt_s = accept_s ? fin_b_s : (seen_b_r | fin_b_s);
        case (mode_eff_s)
            MODE_NONE: fire_s = accept_s;
            MODE_ANY:  fire_s = (fin_a_s | fin_b_s) && !fired_eff_s;
            MODE_JOIN: fire_s = seen_a_nxt_s && seen_b_nxt_s && !fired_eff_s;
            default:   fire_s = seen_a_nxt_s && seen_b_nxt_s && !fired_eff_s;
        endcase
    end

    // State, counters and registered outputs; reset aborts any fork silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_a_r    <= JOB_IDLE;
            st_b_r    <= JOB_IDLE;
            cnt_a_r   <= CNT_ZERO;
            cnt_b_r   <= CNT_ZERO;
            mode_r    <= MODE_JOIN;
            seen_a_r  <= 1'b0;
            seen_b_r  <= 1'b0;
            fired_r   <= 1'b0;
            busy_a    <= 1'b0;
            busy_b    <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            join_done <= 1'b0;
            fork_id   <= 4'd0;
        end else begin
            st_a_r    <= st_a_nxt_s;
            st_b_r    <= st_b_nxt_s;
            cnt_a_r   <= cnt_a_nxt_s;
            cnt_b_r   <= cnt_b_nxt_s;
            mode_r    <= mode_eff_s;
            seen_a_r  <= seen_a_nxt_s;
            seen_b_r  <= seen_b_nxt_s;
            fired_r   <= fired_eff_s | fire_s;
            busy_a    <= (st_a_nxt_s == JOB_RUN);
            busy_b    <= (st_b_nxt_s == JOB_RUN);
            done_a    <= fin_a_s;
            done_b    <= fin_b_s;
            join_done <= fire_s;
            if (accept_s) begin
                fork_id <= fork_id + 4'd1;
            end else begin
                fork_id <= fork_id;
            end
        end
    end

endmodule

// File: doc/fork_join_ctrl.md
# fork_join_ctrl

Synthesizable launcher for two concurrent jobs with SystemVerilog-style join semantics, for the IPC examples. On each accepted start it forks two countdown jobs, A and B, with independent durations. It tracks each job's completion and issues one parent-continue pulse per start. The mode selects join (both done), join_any (first done) or join_none (continue immediately).

## Interface
- CNT_W, 8, width of the job duration operands and countdown counters
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  requester presents a fork request; held until accepted
- start_ready  out  1  block can accept a fork; equals !rst && !busy_a && !busy_b
- mode  in  2  join policy: 00 join, 01 join_any, 10 join_none, 11 reserved (behaves as 00)
- dur_a  in  CNT_W  duration of job A in cycles, sampled at accept
- dur_b  in  CNT_W  duration of job B in cycles, sampled at accept
- busy_a  out  1  job A running
- busy_b  out  1  job B running
- done_a  out  1  one-cycle pulse: job A completed
- done_b  out  1  one-cycle pulse: job B completed
- join_done  out  1  one-cycle pulse: parent may continue under the latched mode
- fork_id  out  4  count of accepted forks modulo 16; increments at each accept

## Operation
- Accept: occurs on the edge where start_valid && start_ready. Latches mode, increments fork_id, loads cnt_a=dur_a and cnt_b=dur_b.
- Per job X, two states: IDLE and RUN.
  - At accept with dur_X≥1: go to RUN, busy_X<=1.
  - At accept with dur_X=0: stay IDLE, done_X<=1 on that same edge.
  - In RUN: cnt_X decrements every edge. On the edge where cnt_X==1: busy_X<=0, done_X<=1, return to IDLE.
- Finishing flag fin_X: 1 on any edge that sets done_X.
- join_done is registered and fires at most once per accepted fork. It is set on the edge where:
  - join_none: the accept edge itself.
  - join_any: the first edge with fin_a||fin_b. A simultaneous finish still gives a single pulse.
  - join / reserved: the edge where the second of fin_a, fin_b occurs, or an edge where both occur together.
- No new accept while either job is busy. start_valid with start_ready=0 is simply held; no error path.
- Once both jobs are idle, the next fork may be accepted immediately. A join_none parent therefore continues at once, while the children keep running and block further forks.
- The latched mode governs the current fork only; changes on mode, dur_a or dur_b between accepts are ignored.

## Timing
- Edge numbering: E0 is the accept edge; Ek is the k-th edge after it.
- done_X is set at edge E_dur_X. This holds uniformly for dur_X=0, which sets done at E0.
- busy_X is high from after E0 through E(dur_X−1): exactly dur_X cycles. It is never high for dur_X=0.
- join_done edge:
  - join_none: E0
  - join_any: E(min(dur_a, dur_b))
  - join: E(max(dur_a, dur_b))
- start_ready returns high in the cycle after E(max(dur_a, dur_b)). A new accept is possible at the next edge.
- Pulses done_a, done_b and join_done clear on the following edge unless re-set by a new event. Back-to-back forks with both durations 0 give one pulse per fork.
- Reset, asynchronous and possible at any time, including mid-RUN:
  - busy_a=busy_b=0, done_a=done_b=0, join_done=0, fork_id=0, counters=0, latched mode=00.
  - start_ready=0 while rst is high and 1 from the first cycle after release.
  - An aborted fork produces no done or join_done pulses.
- Counters are CNT_W bits with no wrap. The maximum duration is 2^CNT_W−1 cycles.

## Test plan
- mode=00, dur_a=20, dur_b=30, accept at E0:
  - done_a at E20; done_b and join_done at E30.
  - start_ready=0 from after E0 through the cycle following E29.
  - fork_id=1.
- mode=01, dur_a=20, dur_b=30:
  - join_done at E20 only.
  - done_b still at E30.
  - A start_valid held from E5 is accepted at E31.
- mode=10, dur_a=20, dur_b=30: join_done at E0; done_a at E20; done_b at E30; exactly one join_done.
- mode=01, dur_a=dur_b=7: done_a, done_b and join_done all at E7, with a single join_done pulse.
- mode=00, dur_a=0, dur_b=0, start_valid held high for 3 cycles:
  - Three accepts on consecutive edges, each with done_a, done_b and join_done at its accept edge.
  - busy never high.
  - fork_id=3.
- mode=00, dur_a=dur_b=50, rst pulsed at E10:
  - All outputs 0 immediately on the reset.
  - No done or join_done afterwards.
  - start_ready=1 the cycle after release.
  - Next fork counts as fork_id=1.
